vga_clut_arb: RTL and testbench
===============================

VGA_CLUT_ARB -- requirements
Module: vga_clut_arb

Interface
REQ-001 SHALL have parameter DWIDTH, default 24, meaning the CLUT entry data width.
REQ-002 SHALL have parameter AWIDTH, default 9, meaning the CLUT address width.
REQ-003 SHALL have parameter HOST_MAX_WAIT, default 4, meaning the maximum consecutive port0 grants while port1 is pending.
REQ-004 SHALL have port wb_clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have ports adr0_i in AWIDTH, cyc0_i in 1, stb0_i in 1, we0_i in 1: port0, the pixel-fetch request (read-only).
REQ-007 SHALL have ports dat0_o out DWIDTH, ack0_o out 1, err0_o out 1: port0 response.
REQ-008 SHALL have ports adr1_i in AWIDTH, dat1_i in DWIDTH, sel1_i in DWIDTH/8, cyc1_i in 1, stb1_i in 1, we1_i in 1: port1, the host request.
REQ-009 SHALL have ports dat1_o out DWIDTH, ack1_o out 1, err1_o out 1: port1 response.
REQ-010 SHALL have ports mem_en_o out 1, mem_we_o out 1, mem_be_o out DWIDTH/8, mem_adr_o out AWIDTH, mem_dat_o out DWIDTH: single-port synchronous RAM command.
REQ-011 SHALL have port mem_dat_i  in  DWIDTH: RAM read data, valid the cycle after the RAM-sampling edge.
REQ-012 SHALL have port busy_o  out  1: state is not IDLE.

Function
REQ-013 SHALL implement a FSM with states IDLE, ACC, RESP; a request on port N is cycN_i & stbN_i.
REQ-014 In IDLE with a valid request, SHALL select a winner, register mem_en_o=1, mem_adr_o, mem_we_o, mem_be_o and mem_dat_o from the winner, and go to ACC.
REQ-015 ACC SHALL last exactly one cycle, keep the mem_* outputs stable, and go to RESP; mem_en_o and mem_we_o SHALL be deasserted on leaving ACC.
REQ-016 RESP SHALL last exactly one cycle, assert the winner's ackN_o for exactly that cycle, drive datN_o=mem_dat_i for a winner read, and return to IDLE.
REQ-017 Latency: a request first seen at IDLE edge T SHALL receive ack during cycle T+2; at most one access per 3 cycles.
REQ-018 datN_o SHALL be all zero whenever ackN_o is low.
REQ-019 Arbitration: port0 SHALL win over port1, except when wait_cnt == HOST_MAX_WAIT, in which case port1 SHALL win.
REQ-020 wait_cnt SHALL increment (saturating at HOST_MAX_WAIT) on each port0 grant made while port1 requests, SHALL clear on a port1 grant, and SHALL clear in any IDLE cycle without a port1 request.
REQ-021 A port0 request with we0_i=1 SHALL NOT access the RAM; err0_o SHALL be pulsed for one cycle at T+1 and the FSM SHALL stay IDLE.
REQ-022 A port1 write with sel1_i all zero SHALL pulse err1_o for one cycle at T+1 without a RAM access.
REQ-023 An error-only request SHALL NOT change wait_cnt; a simultaneous valid request on the other port SHALL be granted in the same IDLE cycle.
REQ-024 If the winner's cycN_i drops during ACC or RESP, the RAM operation SHALL complete, no ack SHALL be issued, and the FSM SHALL still return to IDLE.
REQ-025 ackN_o and errN_o SHALL never be asserted in the same cycle, nor to both ports in the same cycle.

Reset
REQ-026 When wb_rst_i=1 at an edge, SHALL enter IDLE, clear wait_cnt, and drive all outputs to 0 on the next cycle, including mid-ACC or mid-RESP (pending ack dropped).
REQ-027 The first request after reset release SHALL be served with normal T+2 latency.

Verification
REQ-028 Port1 write adr=0x05, dat=0x123456, sel=111, then port0 read adr=0x05 -> ack1 at T+2; port0 ack at its T+2 with dat0_o=0x123456.
REQ-029 Port0 and port1 request simultaneously and continuously, HOST_MAX_WAIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1; each ack exactly 1 cycle.
REQ-030 Port0 we0_i=1 -> err0_o=1 at T+1, mem_en_o stays 0, ack0_o never asserted.
REQ-031 Port1 read started, cyc1_i dropped in ACC -> mem_en_o pulse seen, ack1_o stays 0, busy_o=0 at T+3.
REQ-032 wb_rst_i asserted during RESP -> ack suppressed next cycle, all outputs 0, next request acked at T+2.

Source files
------------

// File: rtl/vga_clut_arb.sv
// Two-port Wishbone arbiter in front of a single-port synchronous CLUT RAM.
// Port0 (pixel fetch) has priority; port1 (host) gets a slot after HOST_MAX_WAIT back-to-back port0 grants.
module vga_clut_arb #(
  parameter int DWIDTH        = 24,
  parameter int AWIDTH        = 9,
  parameter int HOST_MAX_WAIT = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  // port0: pixel fetch, read-only
  input  logic [AWIDTH-1:0]     adr0_i,
  input  logic                  cyc0_i,
  input  logic                  stb0_i,
  input  logic                  we0_i,
  output logic [DWIDTH-1:0]     dat0_o,
  output logic                  ack0_o,
  output logic                  err0_o,
  // port1: host
  input  logic [AWIDTH-1:0]     adr1_i,
  input  logic [DWIDTH-1:0]     dat1_i,
  input  logic [DWIDTH/8-1:0]   sel1_i,
  input  logic                  cyc1_i,
  input  logic                  stb1_i,
  input  logic                  we1_i,
  output logic [DWIDTH-1:0]     dat1_o,
  output logic                  ack1_o,
  output logic                  err1_o,
  // RAM command
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [DWIDTH/8-1:0]   mem_be_o,
  output logic [AWIDTH-1:0]     mem_adr_o,
  output logic [DWIDTH-1:0]     mem_dat_o,
  input  logic [DWIDTH-1:0]     mem_dat_i,
  output logic                  busy_o
);

  localparam int BW = DWIDTH/8;
  localparam int WW = $clog2(HOST_MAX_WAIT + 2);
  localparam logic [WW-1:0] WMAX = WW'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t              r_state;
  logic [WW-1:0]       r_wait;
  logic                r_mem_en, r_mem_we;
  logic [BW-1:0]       r_mem_be;
  logic [AWIDTH-1:0]   r_mem_adr;
  logic [DWIDTH-1:0]   r_mem_dat;
  logic                r_win1, r_rd;
  logic                r_ack0, r_ack1;
  logic                r_err0, r_err1;

  logic w_hreq, w_req0, w_req1, w_bad0, w_bad1, w_ok0, w_ok1, w_g0, w_g1;

  // A port being errored still holds its strobe during the err cycle; mask it so the pulse stays single.
  assign w_hreq = cyc1_i & stb1_i;
  assign w_req0 = cyc0_i & stb0_i & ~r_err0;
  assign w_req1 = w_hreq & ~r_err1;
  assign w_bad0 = w_req0 & we0_i;
  assign w_ok0  = w_req0 & ~we0_i;
  assign w_bad1 = w_req1 & we1_i & (sel1_i == '0);
  assign w_ok1  = w_req1 & ~w_bad1;
  assign w_g1   = w_ok1 & (~w_ok0 | (r_wait == WMAX));
  assign w_g0   = w_ok0 & ~w_g1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_be  <= '0;
      r_mem_adr <= '0;
      r_mem_dat <= '0;
      r_win1    <= 1'b0;
      r_rd      <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
    end else begin
      r_err0 <= 1'b0;
      r_err1 <= 1'b0;
      case (r_state)
        IDLE: begin
          // Only one err per cycle; a simultaneous port1 error is taken on a later IDLE cycle.
          r_err0 <= w_bad0;
          r_err1 <= w_bad1 & ~w_bad0;
          if (w_g1 || !w_hreq)
            r_wait <= '0;
          else if (w_g0 && w_ok1 && r_wait != WMAX)
            r_wait <= r_wait + WW'(1);
          if (w_g0 || w_g1) begin
            r_state   <= ACC;
            r_mem_en  <= 1'b1;
            r_win1    <= w_g1;
            r_mem_we  <= w_g1 & we1_i;
            r_rd      <= ~(w_g1 & we1_i);
            r_mem_adr <= w_g1 ? adr1_i : adr0_i;
            r_mem_be  <= w_g1 ? sel1_i : '1;
            r_mem_dat <= w_g1 ? dat1_i : '0;
          end
        end
        ACC: begin
          r_state  <= RESP;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_ack0   <= ~r_win1 & cyc0_i;
          r_ack1   <= r_win1 & cyc1_i;
        end
        RESP: begin
          r_state <= IDLE;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The ack is also gated by cyc so a master abandoning the cycle during RESP sees no ack.
  assign ack0_o    = r_ack0 & cyc0_i;
  assign ack1_o    = r_ack1 & cyc1_i;
  assign dat0_o    = (ack0_o & r_rd) ? mem_dat_i : '0;
  assign dat1_o    = (ack1_o & r_rd) ? mem_dat_i : '0;
  assign err0_o    = r_err0;
  assign err1_o    = r_err1;
  assign mem_en_o  = r_mem_en;
  assign mem_we_o  = r_mem_we;
  assign mem_be_o  = r_mem_be;
  assign mem_adr_o = r_mem_adr;
  assign mem_dat_o = r_mem_dat;
  assign busy_o    = (r_state != IDLE);

endmodule

// File: tb/tb_vga_clut_arb.sv
// Randomized bench for vga_clut_arb: a shadow CLUT plus outcome rules (latency, grant order,
// error handling) predict every ack/err/data seen on the two Wishbone ports.
module tb_vga_clut_arb;
  localparam int DW = 24, AW = 9, MW = 4, BW = DW/8;

  logic clk = 1'b0, rst;
  logic [AW-1:0] adr0_i, adr1_i, mem_adr_o;
  logic cyc0_i, stb0_i, we0_i, cyc1_i, stb1_i, we1_i;
  logic [DW-1:0] dat0_o, dat1_o, dat1_i, mem_dat_o, mem_dat_i;
  logic [BW-1:0] sel1_i, mem_be_o;
  logic ack0_o, err0_o, ack1_o, err1_o, mem_en_o, mem_we_o, busy_o;

  vga_clut_arb #(.DWIDTH(DW), .AWIDTH(AW), .HOST_MAX_WAIT(MW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .adr0_i(adr0_i), .cyc0_i(cyc0_i), .stb0_i(stb0_i), .we0_i(we0_i),
    .dat0_o(dat0_o), .ack0_o(ack0_o), .err0_o(err0_o),
    .adr1_i(adr1_i), .dat1_i(dat1_i), .sel1_i(sel1_i), .cyc1_i(cyc1_i), .stb1_i(stb1_i), .we1_i(we1_i),
    .dat1_o(dat1_o), .ack1_o(ack1_o), .err1_o(err1_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .busy_o(busy_o));

  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the command bus
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o)
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) ram[mem_adr_o][8*b +: 8] <= mem_dat_o[8*b +: 8];
      mem_dat_i <= ram[mem_adr_o];
    end
  end

  logic any_out;
  assign any_out = |{dat0_o, ack0_o, err0_o, dat1_o, ack1_o, err1_o,
                     mem_en_o, mem_we_o, mem_be_o, mem_adr_o, mem_dat_o, busy_o};

  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  int ka0, ke0, ka1, ke1, nen, nack, nerr, viol;
  logic [DW-1:0] rd0, rd1;
  logic busy3;

  // Present one request per port (v0/v1) in the current cycle, then watch 12 cycles.
  // k counts rising edges since the request was first presented. abN>0 drops portN in cycle k=abN.
  task automatic issue(input bit v0, input bit w0, input logic [AW-1:0] a0, input int ab0,
                       input bit v1, input bit w1, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d1, input logic [BW-1:0] s1, input int ab1);
    bit drop0, drop1;
    ka0 = -1; ke0 = -1; ka1 = -1; ke1 = -1;
    nen = 0; nack = 0; nerr = 0; viol = 0; busy3 = 1'b1; rd0 = '0; rd1 = '0;
    drop0 = 1'b0; drop1 = 1'b0;
    cyc0_i = v0; stb0_i = v0; we0_i = w0; adr0_i = a0;
    cyc1_i = v1; stb1_i = v1; we1_i = w1; adr1_i = a1; dat1_i = d1; sel1_i = s1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (drop0 || k == ab0) begin cyc0_i = 1'b0; stb0_i = 1'b0; end
      if (drop1 || k == ab1) begin cyc1_i = 1'b0; stb1_i = 1'b0; end
      @(negedge clk);
      if (mem_en_o) nen++;
      if (k == 3) busy3 = busy_o;
      if (ack0_o) begin nack++; drop0 = 1'b1; if (ka0 < 0) begin ka0 = k; rd0 = dat0_o; end end
      if (ack1_o) begin nack++; drop1 = 1'b1; if (ka1 < 0) begin ka1 = k; rd1 = dat1_o; end end
      if (err0_o) begin nerr++; drop0 = 1'b1; if (ke0 < 0) ke0 = k; end
      if (err1_o) begin nerr++; drop1 = 1'b1; if (ke1 < 0) ke1 = k; end
      if ((ack0_o || err0_o) && (ack1_o || err1_o)) viol++;
      if ((ack0_o && err0_o) || (ack1_o && err1_o)) viol++;
      if ((!ack0_o && dat0_o != '0) || (!ack1_o && dat1_o != '0)) viol++;
    end
    chk("busy_after", int'(busy_o), 0);
    chk("protocol_viol", viol, 0);
  endtask

  task automatic shadow_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] s);
    for (int b = 0; b < BW; b++)
      if (s[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
  endtask

  bit v0, w0, v1, w1, bad0, bad1, ok0, ok1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d1, e_rd0, e_rd1;
  logic [BW-1:0] s1;
  int streak, grants, last_c, gap_bad, both_ack;

  initial begin
    rst = 1'b1;
    cyc0_i = 0; stb0_i = 0; we0_i = 0; adr0_i = '0;
    cyc1_i = 0; stb1_i = 0; we1_i = 0; adr1_i = '0; dat1_i = '0; sel1_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", int'(any_out), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Fill the low addresses through the host port; first one also covers post-reset latency
    for (int i = 0; i < 16; i++) begin
      a1 = AW'(i); d1 = DW'($urandom);
      issue(0, 0, '0, 0, 1, 1, a1, d1, '1, 0);
      chk("fill_ack1_lat", ka1, 2);
      chk("fill_nen", nen, 1);
      shadow_write(a1, d1, '1);
    end

    // Host write 0x123456 to 5, then pixel read of 5
    issue(0, 0, '0, 0, 1, 1, 9'h05, 24'h123456, 3'b111, 0);
    chk("w5_ack1_lat", ka1, 2);
    shadow_write(9'h05, 24'h123456, 3'b111);
    issue(1, 0, 9'h05, 0, 0, 0, '0, '0, '0, 0);
    chk("r5_ack0_lat", ka0, 2);
    chk("r5_dat0", int'(rd0), int'(24'h123456));
    chk("r5_nack", nack, 1);

    // Pixel write is an error: err at k=1, no RAM access, no ack
    issue(1, 1, 9'h03, 0, 0, 0, '0, '0, '0, 0);
    chk("we0_err_lat", ke0, 1);
    chk("we0_nen", nen, 0);
    chk("we0_nack", nack, 0);
    chk("we0_nerr", nerr, 1);

    // Host write with empty byte select is an error
    issue(0, 0, '0, 0, 1, 1, 9'h04, 24'hABCDEF, 3'b000, 0);
    chk("sel0_err_lat", ke1, 1);
    chk("sel0_nen", nen, 0);
    chk("sel0_nack", nack, 0);

    // Host read abandoned during ACC and during RESP
    for (int ab = 1; ab <= 2; ab++) begin
      issue(0, 0, '0, 0, 1, 0, 9'h02, '0, '1, ab);
      chk("abort_nen", nen, 1);
      chk("abort_ack1", ka1, -1);
      chk("abort_busy_t3", int'(busy3), 0);
    end

    // Randomized single and paired requests
    for (int it = 0; it < 60; it++) begin
      v0 = ($urandom_range(0, 3) != 0); w0 = ($urandom_range(0, 4) == 0);
      v1 = ($urandom_range(0, 2) != 0); w1 = 1'($urandom_range(0, 1));
      a0 = AW'($urandom_range(0, 15)); a1 = AW'($urandom_range(0, 15));
      d1 = DW'($urandom); s1 = BW'($urandom_range(0, 7));
      if (!v0 && !v1) v0 = 1'b1;
      bad0 = v0 && w0;
      bad1 = v1 && w1 && (s1 == '0);
      if (bad0 && bad1) begin w0 = 1'b0; bad0 = 1'b0; end
      ok0 = v0 && !bad0;
      ok1 = v1 && !bad1;
      e_rd0 = shadow[a0];
      e_rd1 = shadow[a1];
      issue(v0, w0, a0, 0, v1, w1, a1, d1, s1, 0);
      chk("rnd_ack0", ka0, ok0 ? 2 : -1);
      chk("rnd_err0", ke0, bad0 ? 1 : -1);
      chk("rnd_ack1", ka1, ok1 ? (ok0 ? 5 : 2) : -1);
      chk("rnd_err1", ke1, bad1 ? 1 : -1);
      chk("rnd_nen", nen, int'(ok0) + int'(ok1));
      chk("rnd_nack", nack, int'(ok0) + int'(ok1));
      chk("rnd_nerr", nerr, int'(bad0) + int'(bad1));
      if (ok0) chk("rnd_dat0", int'(rd0), int'(e_rd0));
      if (ok1 && !w1) chk("rnd_dat1", int'(rd1), int'(e_rd1));
      if (ok1 && w1) shadow_write(a1, d1, s1);
    end

    // Continuous contention: port1 gets one slot after every MW port0 grants
    cyc0_i = 1; stb0_i = 1; we0_i = 0; adr0_i = AW'($urandom_range(0, 15));
    cyc1_i = 1; stb1_i = 1; we1_i = 0; adr1_i = AW'($urandom_range(0, 15)); sel1_i = '1;
    streak = 0; grants = 0; last_c = -1; gap_bad = 0; both_ack = 0;
    for (int c = 1; c <= 60 && grants < 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (ack0_o && ack1_o) both_ack++;
      if (ack0_o || ack1_o) begin
        if (last_c >= 0 && c - last_c != 3) gap_bad++;
        last_c = c;
        chk("arb_order", int'(ack1_o), (streak == MW) ? 1 : 0);
        streak = ack1_o ? 0 : streak + 1;
        if (ack0_o) chk("arb_dat0", int'(dat0_o), int'(shadow[adr0_i]));
        if (ack1_o) chk("arb_dat1", int'(dat1_o), int'(shadow[adr1_i]));
        grants++;
        @(posedge clk); #1;
        if (ack0_o) adr0_i = AW'($urandom_range(0, 15));
        if (ack1_o) adr1_i = AW'($urandom_range(0, 15));
        c++;
        @(negedge clk);
        if (ack0_o || ack1_o) gap_bad++;
      end
    end
    chk("arb_grants", grants, 10);
    chk("arb_gap", gap_bad, 0);
    chk("arb_both_ack", both_ack, 0);
    cyc0_i = 0; stb0_i = 0; cyc1_i = 0; stb1_i = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset while in RESP with the request still held
    cyc0_i = 1; stb0_i = 1; we0_i = 0; adr0_i = 9'h05;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("resp_ack0_before_rst", int'(ack0_o), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_resp_outs", int'(any_out), 0);
    @(posedge clk); #1;
    chk("rst_hold_outs", int'(any_out), 0);
    rst = 1'b0; cyc0_i = 0; stb0_i = 0;
    issue(1, 0, 9'h05, 0, 0, 0, '0, '0, '0, 0);
    chk("post_rst_ack0_lat", ka0, 2);
    chk("post_rst_dat0", int'(rd0), int'(shadow[9'h05]));

    // Reset while in ACC: the pending ack never appears
    cyc1_i = 1; stb1_i = 1; we1_i = 0; adr1_i = 9'h07; sel1_i = '1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc_outs", int'(any_out), 0);
    @(posedge clk); #1;
    chk("rst_acc_ack1", int'(ack1_o), 0);
    rst = 1'b0; cyc1_i = 0; stb1_i = 0;
    issue(0, 0, '0, 0, 1, 0, 9'h07, '0, '1, 0);
    chk("post_rst_ack1_lat", ka1, 2);
    chk("post_rst_dat1", int'(rd1), int'(shadow[9'h07]));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
